// File: rtl/shufflev_rng_arb.sv
// Round-robin arbiter that hands each requester a bounded random number.
// Ports: clk_i/rst_ni, rng_* word stream, req_i/bound_i in, gnt_o/number_o/reject_cnt_o out.
module shufflev_rng_arb #(
  parameter int NumReq   = 4,
  parameter int BoundW   = 4,
  parameter int MaxRetry = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [31:0]              rng_number_i,
  input  logic                     rng_valid_i,
  output logic                     rng_ack_o,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq*BoundW-1:0] bound_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [BoundW-1:0]        number_o,
  output logic [15:0]              reject_cnt_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [1:0] Idle   = 2'd0;
  localparam logic [1:0] Sample = 2'd1;
  localparam logic [1:0] Resp   = 2'd2;

  logic [1:0]        state_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [BoundW-1:0] bound_q;
  logic [BoundW-1:0] result_q;
  logic [3:0]        retry_q;
  logic [15:0]       reject_cnt_q;

  logic [IdxW-1:0]   sel_idx;
  logic              any_req;
  logic [BoundW-1:0] mask;
  logic [BoundW-1:0] cand;
  logic [BoundW-1:0] fallback;
  logic              cand_ok;
  logic              retry_max;
  logic              req_held;
  logic              unused_rng;

  assign unused_rng = ^rng_number_i[31:BoundW];

  // First set request at or after rr_ptr: scan offsets high to low so
  // the smallest offset is the last (winning) assignment.
  always_comb begin
    int p;
    p       = 0;
    sel_idx = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      p = (int'(rr_ptr_q) + k) % NumReq;
      if (req_i[p]) sel_idx = IdxW'(p);
    end
  end

  assign any_req = |req_i;

  // Smallest all-ones mask covering the bound.
  always_comb begin
    mask = '0;
    for (int j = 0; j < BoundW; j++) begin
      mask[j] = |(bound_q >> j);
    end
  end

  assign cand      = rng_number_i[BoundW-1:0] & mask;
  assign cand_ok   = cand <= bound_q;
  assign fallback  = cand - bound_q - BoundW'(1);
  assign retry_max = retry_q == 4'(MaxRetry);
  assign req_held  = req_i[idx_q];

  assign rng_ack_o = (state_q == Sample) && rng_valid_i && req_held;

  always_comb begin
    gnt_o = '0;
    if (state_q == Resp) gnt_o[idx_q] = 1'b1;
  end

  assign number_o     = (state_q == Resp) ? result_q : '0;
  assign reject_cnt_o = reject_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= Idle;
      idx_q        <= '0;
      rr_ptr_q     <= '0;
      bound_q      <= '0;
      result_q     <= '0;
      retry_q      <= '0;
      reject_cnt_q <= '0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (any_req) begin
            idx_q   <= sel_idx;
            bound_q <= bound_i[int'(sel_idx)*BoundW +: BoundW];
            retry_q <= '0;
            state_q <= Sample;
          end
        end
        Sample: begin
          if (!req_held) begin
            state_q <= Idle;
          end else if (rng_valid_i) begin
            if (cand_ok) begin
              result_q <= cand;
              state_q  <= Resp;
            end else if (!retry_max) begin
              retry_q <= retry_q + 4'd1;
              if (reject_cnt_q != 16'hFFFF)
                reject_cnt_q <= reject_cnt_q + 16'd1;
            end else begin
              // cand is at most 2*bound+1, so this lands in 0..bound
              result_q <= fallback;
              state_q  <= Resp;
            end
          end
        end
        Resp: begin
          rr_ptr_q <= (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
          state_q  <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_shufflev_rng_arb.sv
// Directed bench for shufflev_rng_arb with hand-computed expectations.
// Drives inputs and samples outputs 1ns after each rising edge.
module tb_shufflev_rng_arb;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] rng_number_i;
  logic        rng_valid_i;
  logic        rng_ack_o;
  logic [3:0]  req_i;
  logic [15:0] bound_i;
  logic [3:0]  gnt_o;
  logic [3:0]  number_o;
  logic [15:0] reject_cnt_o;

  int n_cmp;
  int n_err;

  shufflev_rng_arb #(
    .NumReq(4),
    .BoundW(4),
    .MaxRetry(3)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .rng_number_i(rng_number_i),
    .rng_valid_i(rng_valid_i),
    .rng_ack_o(rng_ack_o),
    .req_i(req_i),
    .bound_i(bound_i),
    .gnt_o(gnt_o),
    .number_o(number_o),
    .reject_cnt_o(reject_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0] exp_g [5];
  logic [3:0] nib [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_ni       = 1'b0;
    rng_number_i = '0;
    rng_valid_i  = 1'b0;
    req_i        = '0;
    bound_i      = '0;
    #12;
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_num", 32'(number_o), 0);
    chk("rst_ack", 32'(rng_ack_o), 0);
    chk("rst_rej", 32'(reject_cnt_o), 0);
    rst_ni = 1'b1;
    step();

    // round robin, all requesting, bound 15
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bound_i      = 16'hFFFF;
    rng_number_i = 32'hF;
    rng_valid_i  = 1'b1;
    req_i        = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_wait", 32'(gnt_o), 0);
      step();
      chk("rr_gnt", 32'(gnt_o), 32'(exp_g[g]));
      step();
      chk("rr_pulse", 32'(gnt_o), 0);
    end
    req_i = '0;
    step();

    // basic grant, bound change after latch must not matter
    bound_i      = 16'h0003;
    rng_number_i = 32'hABC6;
    req_i        = 4'b0001;
    step();
    bound_i = 16'h0000;
    chk("b_ack", 32'(rng_ack_o), 1);
    chk("b_gnt0", 32'(gnt_o), 0);
    step();
    chk("b_gnt", 32'(gnt_o), 32'h1);
    chk("b_num", 32'(number_o), 2);
    req_i = '0;
    step();
    chk("b_idle", 32'(gnt_o), 0);
    chk("b_num0", 32'(number_o), 0);

    // three rejects then fallback 7-(5+1)=1
    nib = '{4'd7, 4'd6, 4'd7, 4'd7};
    bound_i      = 16'h0005;
    rng_number_i = 32'h7;
    req_i        = 4'b0001;
    step();
    for (int r = 0; r < 4; r++) begin
      rng_number_i = 32'(nib[r]);
      step();
    end
    chk("fb_gnt", 32'(gnt_o), 32'h1);
    chk("fb_num", 32'(number_o), 1);
    chk("fb_rej", 32'(reject_cnt_o), 3);
    req_i = '0;
    step();

    // bound 0 on requester 2
    bound_i      = 16'hF0FF;
    rng_number_i = 32'hF;
    req_i        = 4'b0100;
    step();
    step();
    chk("z_gnt", 32'(gnt_o), 32'h4);
    chk("z_num", 32'(number_o), 0);
    chk("z_rej", 32'(reject_cnt_o), 3);
    req_i = '0;
    step();

    // stall with no valid word, then drop the request
    bound_i     = 16'hFFFF;
    rng_valid_i = 1'b0;
    req_i       = 4'b0001;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("st_ack", 32'(rng_ack_o), 0);
      chk("st_gnt", 32'(gnt_o), 0);
      step();
    end
    req_i = '0;
    step();
    chk("dr_gnt", 32'(gnt_o), 0);
    // back in IDLE: a new request needs the full two cycles
    req_i        = 4'b0001;
    rng_valid_i  = 1'b1;
    rng_number_i = 32'h5;
    step();
    chk("dr_wait", 32'(gnt_o), 0);
    chk("dr_ack", 32'(rng_ack_o), 1);
    step();
    chk("dr_gnt2", 32'(gnt_o), 32'h1);
    chk("dr_num", 32'(number_o), 5);
    req_i = '0;
    step();

    // reset in SAMPLE, then normal service of requester 1
    rng_valid_i  = 1'b0;
    rng_number_i = 32'h9;
    req_i        = 4'b0010;
    step();
    rng_valid_i = 1'b1;
    #1;
    chk("pr_ack", 32'(rng_ack_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("ar_ack", 32'(rng_ack_o), 0);
    chk("ar_gnt", 32'(gnt_o), 0);
    chk("ar_num", 32'(number_o), 0);
    chk("ar_rej", 32'(reject_cnt_o), 0);
    step();
    rst_ni = 1'b1;
    step();
    chk("rs_wait", 32'(gnt_o), 0);
    step();
    chk("rs_gnt", 32'(gnt_o), 32'h2);
    chk("rs_num", 32'(number_o), 9);
    req_i = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
